// File: rtl/adc_sample_scheduler.sv
// ADC conversion scheduler: each 50 Hz strobe starts a frame of evenly spaced CONVST
// pulses, tracks the BUSY handshake per slot and keeps sticky timing error flags.
module adc_sample_scheduler #(
    parameter int SAMPLES_PER_CYCLE = 64,
    parameter int CLKS_PER_SAMPLE   = 1024,
    parameter int CONVST_WIDTH      = 4,
    parameter int BUSY_TIMEOUT      = 64
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 PULSE_50_HZ,
    input  logic                                 ADC_BUSY,
    input  logic                                 CLR_FLAGS,
    output logic                                 CONVST,
    output logic                                 SAMPLE_READY,
    output logic [$clog2(SAMPLES_PER_CYCLE)-1:0] SAMPLE_IDX,
    output logic                                 FRAME_ACTIVE,
    output logic                                 FRAME_DONE,
    output logic                                 TIMEOUT_ERR,
    output logic                                 OVERRUN_ERR,
    output logic                                 FRAME_SHORT_ERR
);
    localparam int SW      = $clog2(SAMPLES_PER_CYCLE);
    localparam int TW      = $clog2(CLKS_PER_SAMPLE);
    localparam int CNT_MAX = (CONVST_WIDTH > BUSY_TIMEOUT) ? CONVST_WIDTH : BUSY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SAMPLES_PER_CYCLE - 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(CONVST_WIDTH - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] slot, slot_n;
    logic [TW-1:0] timer, timer_n;
    logic          busy_meta, busy_s;
    logic          active, wrap, last_slot;
    logic          ready_n, done_n, to_set, ov_set, sh_set;

    assign active    = (state != IDLE);
    assign wrap      = active && (timer == TIMER_LAST);
    assign last_slot = (slot == SLOT_LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        slot_n  = slot;
        timer_n = timer;
        ready_n = 1'b0;
        done_n  = 1'b0;
        to_set  = 1'b0;
        ov_set  = 1'b0;
        sh_set  = 1'b0;

        if (active) timer_n = wrap ? '0 : timer + 1'b1;

        case (state)
            IDLE: begin
            end
            CONV: begin
                if (cnt == CONV_LAST) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HI: begin
                if (busy_s) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    to_set  = 1'b1;
                    done_n  = last_slot;
                    state_n = last_slot ? IDLE : GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy_s) begin
                    ready_n = 1'b1;
                    done_n  = last_slot;
                    state_n = last_slot ? IDLE : GAP;
                end
            end
            GAP: begin
                if (wrap) begin
                    state_n = CONV;
                    cnt_n   = '0;
                    slot_n  = slot + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Slot boundary reached with the conversion unresolved; an abandoned last slot
        // closes the frame without FRAME_DONE.
        if (wrap && (state == CONV || state == WAIT_HI || state == WAIT_LO)) begin
            ov_set  = 1'b1;
            ready_n = 1'b0;
            done_n  = 1'b0;
            to_set  = 1'b0;
            cnt_n   = '0;
            if (last_slot) begin
                state_n = IDLE;
            end else begin
                state_n = CONV;
                slot_n  = slot + 1'b1;
            end
        end

        // A strobe on the frame's closing edge is a normal back-to-back start.
        if (PULSE_50_HZ) begin
            if (active && !done_n) begin
                sh_set  = 1'b1;
                ready_n = 1'b0;
            end
            state_n = CONV;
            cnt_n   = '0;
            slot_n  = '0;
            timer_n = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_meta       <= 1'b0;
            busy_s          <= 1'b0;
            state           <= IDLE;
            cnt             <= '0;
            slot            <= '0;
            timer           <= '0;
            CONVST          <= 1'b0;
            SAMPLE_READY    <= 1'b0;
            SAMPLE_IDX      <= '0;
            FRAME_ACTIVE    <= 1'b0;
            FRAME_DONE      <= 1'b0;
            TIMEOUT_ERR     <= 1'b0;
            OVERRUN_ERR     <= 1'b0;
            FRAME_SHORT_ERR <= 1'b0;
        end else begin
            busy_meta       <= ADC_BUSY;
            busy_s          <= busy_meta;
            state           <= state_n;
            cnt             <= cnt_n;
            slot            <= slot_n;
            timer           <= timer_n;
            CONVST          <= (state_n == CONV);
            SAMPLE_READY    <= ready_n;
            if (ready_n) SAMPLE_IDX <= slot;
            FRAME_ACTIVE    <= (state_n != IDLE);
            FRAME_DONE      <= done_n;
            TIMEOUT_ERR     <= to_set | (TIMEOUT_ERR & ~CLR_FLAGS);
            OVERRUN_ERR     <= ov_set | (OVERRUN_ERR & ~CLR_FLAGS);
            FRAME_SHORT_ERR <= sh_set | (FRAME_SHORT_ERR & ~CLR_FLAGS);
        end
    end
endmodule
